// File: rtl/inv_mix_columns_seq_if.sv
// Handshake bundle for the column-serial InvMixColumns stage.
// slave is the stage itself; master is the upstream/downstream side driving it.
interface inv_mix_columns_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    modport slave (
        input  in_valid,
        input  state_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output state_out,
        output busy
    );

    modport master (
        output in_valid,
        output state_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  state_out,
        input  busy
    );
endinterface

// File: rtl/inv_mix_columns_seq.sv
// AES InvMixColumns, one 32-bit column per clock, updated in place in a single
// 128-bit working register behind a valid/ready handshake.
module inv_mix_columns_seq (
    input  logic                 clk,
    input  logic                 rst_n,
    inv_mix_columns_seq_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for a block, in_ready high
    // CALC  | transforming column cnt_q, one column per cycle
    // DONE  | result on state_out, waiting for out_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   cnt_q;
    logic [127:0] work_q;
    logic         load;
    logic         calc_en;
    logic         in_ready_c;
    logic         out_valid_c;
    logic [31:0]  col_in;
    logic [31:0]  col_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul_9(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] mul_b(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] mul_d(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] mul_e(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {mul_e(a0) ^ mul_b(a1) ^ mul_d(a2) ^ mul_9(a3),
                mul_9(a0) ^ mul_e(a1) ^ mul_b(a2) ^ mul_d(a3),
                mul_d(a0) ^ mul_9(a1) ^ mul_e(a2) ^ mul_b(a3),
                mul_b(a0) ^ mul_d(a1) ^ mul_9(a2) ^ mul_e(a3)};
    endfunction

    // Column 0 occupies the most significant word.
    always_comb begin
        col_in = work_q[127:96];
        case (cnt_q)
            2'd0:    col_in = work_q[127:96];
            2'd1:    col_in = work_q[95:64];
            2'd2:    col_in = work_q[63:32];
            default: col_in = work_q[31:0];
        endcase
    end

    assign col_out = inv_col(col_in);

    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        calc_en     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_d = CALC;
            end
            CALC: begin
                calc_en = 1'b1;
                if (cnt_q == 2'd3) state_d = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                in_ready_c  = bus.out_ready;
                if (bus.out_ready) state_d = bus.in_valid ? CALC : IDLE;
            end
            default: state_d = IDLE;
        endcase
        load = bus.in_valid & in_ready_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            work_q <= 128'd0;
        end else if (load) begin
            cnt_q  <= 2'd0;
            work_q <= bus.state_in;
        end else if (calc_en) begin
            case (cnt_q)
                2'd0:    work_q[127:96] <= col_out;
                2'd1:    work_q[95:64]  <= col_out;
                2'd2:    work_q[63:32]  <= col_out;
                default: work_q[31:0]   <= col_out;
            endcase
            cnt_q <= cnt_q + 2'd1;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = (state_q == CALC) || (state_q == DONE);
    assign bus.state_out = work_q;
endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Bench for inv_mix_columns_seq: known vectors, random blocks against a generic
// GF(2^8) matrix model, and handshake / reset corner cases.
module tb_inv_mix_columns_seq;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    inv_mix_columns_seq_if bus ();

    inv_mix_columns_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t vecs[4];

    // Generic shift-and-add multiply, reduced by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int acc;
        int aa;
        acc = 0;
        aa  = int'(a);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = aa << 1;
            if ((aa & 'h100) != 0) aa = aa ^ 'h11b;
        end
        return acc[7:0];
    endfunction

    function automatic logic [127:0] ref_model(input logic [127:0] s);
        logic [7:0] m [4][4];
        logic [7:0] a [16];
        logic [7:0] b;
        logic [127:0] r;
        m = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09},
              '{8'h09, 8'h0e, 8'h0b, 8'h0d},
              '{8'h0d, 8'h09, 8'h0e, 8'h0b},
              '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
        for (int i = 0; i < 16; i++) a[i] = s[127 - 8*i -: 8];
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                b = 8'h00;
                for (int k = 0; k < 4; k++) b = b ^ gmul(m[row][k], a[4*c + k]);
                r[127 - 8*(4*c + row) -: 8] = b;
            end
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called #1 after a rising edge with the DUT idle; returns result and
    // number of edges from accept to out_valid, then completes the handshake.
    task automatic send(input logic [127:0] blk, output logic [127:0] res, output int lat);
        bus.in_valid  = 1'b1;
        bus.state_in  = blk;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        do begin
            bus.state_in = rand_block();
            @(posedge clk); #1;
            lat++;
        end while (!bus.out_valid && lat < 20);
        res = bus.state_out;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] blk;
        logic [127:0] held;
        logic [127:0] blk_a, blk_b;
        logic [127:0] res_q[2];
        int           t_q[2];
        int           lat;
        int           cyc;
        int           seen;

        errors = 0;
        checks = 0;
        vecs[0] = '{128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 128'hdb135345_f20a225c_01010101_2d26314c};
        vecs[1] = '{128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6, 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6};
        vecs[2] = '{128'h0, 128'h0};
        vecs[3] = '{128'h046681e5_e0cb199a_48f8d37a_2806264c, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.state_in  = '0;
        #12;
        chk("reset in_ready",  {127'd0, bus.in_ready},  128'd1);
        chk("reset out_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("reset busy",      {127'd0, bus.busy},      128'd0);
        chk("reset state_out", bus.state_out,           128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            send(vecs[i].din, res, lat);
            chk($sformatf("vector %0d result", i), res, vecs[i].dout);
            chk($sformatf("vector %0d latency", i), 128'(lat), 128'd4);
        end

        for (int i = 0; i < 20; i++) begin
            blk = rand_block();
            send(blk, res, lat);
            chk($sformatf("random %0d result", i), res, ref_model(blk));
        end

        // Backpressure: DONE must hold while a new block waits upstream.
        blk = rand_block();
        bus.in_valid = 1'b1;
        bus.state_in = blk;
        @(posedge clk); #1;
        bus.state_in = rand_block();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        chk("bp out_valid at E+4", {127'd0, bus.out_valid}, 128'd1);
        held = bus.state_out;
        chk("bp result", held, ref_model(blk));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp %0d state_out", i), bus.state_out, held);
            chk($sformatf("bp %0d out_valid", i), {127'd0, bus.out_valid}, 128'd1);
            chk($sformatf("bp %0d in_ready", i),  {127'd0, bus.in_ready},  128'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("bp release in_ready", {127'd0, bus.in_ready}, 128'd1);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("bp after out_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("bp after busy",      {127'd0, bus.busy},      128'd0);
        chk("bp after in_ready",  {127'd0, bus.in_ready},  128'd1);

        // Back-to-back: second block taken on the first block's handshake edge.
        blk_a = rand_block();
        blk_b = rand_block();
        bus.in_valid  = 1'b1;
        bus.state_in  = blk_a;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.state_in = blk_b;
        cyc  = 0;
        seen = 0;
        t_q[0] = 0;
        t_q[1] = 0;
        res_q[0] = '0;
        res_q[1] = '0;
        while (seen < 2 && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            if (seen == 1) bus.in_valid = 1'b0;
            if (bus.out_valid) begin
                t_q[seen]   = cyc;
                res_q[seen] = bus.state_out;
                seen++;
            end
        end
        chk("b2b blocks seen", 128'(seen), 128'd2);
        chk("b2b first time",  128'(t_q[0]), 128'd4);
        chk("b2b spacing",     128'(t_q[1] - t_q[0]), 128'd5);
        chk("b2b first result",  res_q[0], ref_model(blk_a));
        chk("b2b second result", res_q[1], ref_model(blk_b));
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("b2b idle after", {127'd0, bus.busy}, 128'd0);

        // Asynchronous reset after two CALC edges.
        bus.in_valid = 1'b1;
        bus.state_in = rand_block();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre-reset busy", {127'd0, bus.busy}, 128'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async out_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("async in_ready",  {127'd0, bus.in_ready},  128'd1);
        chk("async busy",      {127'd0, bus.busy},      128'd0);
        chk("async state_out", bus.state_out,           128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        blk = rand_block();
        send(blk, res, lat);
        chk("post-reset result",  res, ref_model(blk));
        chk("post-reset latency", 128'(lat), 128'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
